// File: rtl/mkio_pkg.sv
// Shared MIL-STD-1553 style definitions used by the MKIO transmitter and receiver.
// Holds the state encoding, the word's half-bit layout and the parity rule.
package mkio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } mkio_state_e;

    localparam int SYNC_HALFBITS   = 6;
    localparam int DATA_HALFBITS   = 32;
    localparam int PARITY_HALFBITS = 2;
    localparam int WORD_HALFBITS   = SYNC_HALFBITS + DATA_HALFBITS + PARITY_HALFBITS;

    // Last half-bit index of each section, counted from the start of the word.
    localparam logic [5:0] SYNC_FLIP = 6'(SYNC_HALFBITS / 2);
    localparam logic [5:0] SYNC_LAST = 6'(SYNC_HALFBITS - 1);
    localparam logic [5:0] DATA_LAST = 6'(SYNC_HALFBITS + DATA_HALFBITS - 1);
    localparam logic [5:0] WORD_LAST = 6'(WORD_HALFBITS - 1);

    // Odd parity over data plus parity bit: set when the data has an even ones count.
    function automatic logic odd_parity(input logic [15:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/mkio_bit_timer.sv
// Half-bit cycle timer: restarts on load, counts while run is high and strobes
// expire in the last cycle of each half-bit.
module mkio_bit_timer #(
    parameter int HALF_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expire
);

    logic [7:0] count_q;

    assign expire = run && (count_q == 8'(HALF_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load || expire) begin
            count_q <= '0;
        end else if (run) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/mkio_transmitter.sv
// MKIO word transmitter: serialises a 16-bit word as sync + Manchester II data
// + odd parity, 40 half-bits per word, driving a complementary line pair.
module mkio_transmitter
    import mkio_pkg::*;
#(
    parameter int HALF_BIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_cd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        line_p,
    output logic        line_n
);

    // Handshake: a word is taken on any rising edge with tx_ready=1 and tx_busy=0;
    // tx_ready is ignored while busy. tx_done pulses once in the first idle cycle.

    mkio_state_e state_q, state_d;
    logic [5:0]  hb_q, hb_d;
    logic [15:0] shreg_q, shreg_d;
    logic        cd_q, cd_d;
    logic        par_q, par_d;
    logic        done_q, done_d;
    logic        load;
    logic        expire;
    logic        line_bit;

    mkio_bit_timer #(
        .HALF_BIT(HALF_BIT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .run   (tx_busy),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hb_q    <= '0;
            shreg_q <= '0;
            cd_q    <= 1'b0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hb_q    <= hb_d;
            shreg_q <= shreg_d;
            cd_q    <= cd_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hb_d    = hb_q;
        shreg_d = shreg_q;
        cd_d    = cd_q;
        par_d   = par_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tx_ready) begin
                    state_d = ST_SYNC;
                    hb_d    = '0;
                    shreg_d = tx_data;
                    cd_d    = tx_cd;
                    par_d   = odd_parity(tx_data);
                    load    = 1'b1;
                end
            end
            ST_SYNC: begin
                if (expire) begin
                    hb_d = hb_q + 6'd1;
                    if (hb_q == SYNC_LAST) begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (expire) begin
                    hb_d = hb_q + 6'd1;
                    // Odd half-bit index is the second half of a data bit.
                    if (hb_q[0]) begin
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end
                    if (hb_q == DATA_LAST) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (expire) begin
                    if (hb_q == WORD_LAST) begin
                        state_d = ST_IDLE;
                        hb_d    = '0;
                        done_d  = 1'b1;
                    end else begin
                        hb_d = hb_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data and parity start on even half-bit indices, so hb_q[0] selects the half.
    always_comb begin
        line_bit = 1'b0;
        case (state_q)
            ST_SYNC:   line_bit = (hb_q < SYNC_FLIP) ? ~cd_q : cd_q;
            ST_DATA:   line_bit = shreg_q[15] ^ hb_q[0];
            ST_PARITY: line_bit = par_q ^ hb_q[0];
            default:   line_bit = 1'b0;
        endcase
    end

    assign tx_busy = (state_q != ST_IDLE);
    assign tx_done = done_q;
    assign line_p  = line_bit;
    assign line_n  = tx_busy & ~line_bit;

endmodule

// File: tb/tb_mkio_transmitter.sv
// Self-checking bench for mkio_transmitter with HALF_BIT=4 (160-cycle words).
// Expected line waveforms come from a half-bit level model of the word format.
module tb_mkio_transmitter;

    localparam int HB       = 4;
    localparam int WORD_CYC = 40 * HB;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_cd;
    logic        tx_busy;
    logic        tx_done;
    logic        line_p;
    logic        line_n;

    int n_cmp = 0;
    int n_err = 0;

    // Each entry: {tx_busy, tx_done, line_p, line_n} for one clk cycle.
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    mkio_transmitter #(
        .HALF_BIT(HB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_ready(tx_ready),
        .tx_data (tx_data),
        .tx_cd   (tx_cd),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .line_p  (line_p),
        .line_n  (line_n)
    );

    // Level of line_p in cycle cyc of a word, from the word's half-bit layout.
    function automatic logic exp_line(input logic [15:0] d, input logic cd, input int cyc);
        int   h;
        int   ones;
        logic b;
        h = cyc / HB;
        if (h < 6) return (h < 3) ? ~cd : cd;
        if (h < 38) begin
            b = d[15 - (h - 6) / 2];
            return ((h - 6) % 2 == 0) ? b : ~b;
        end
        ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(d[i]);
        b = (ones % 2 == 0);
        return (h == 38) ? b : ~b;
    endfunction

    task automatic build_word(input logic [15:0] d, input logic cd);
        logic b;
        exp_q.delete();
        for (int c = 0; c < WORD_CYC; c++) begin
            b = exp_line(d, cd, c);
            exp_q.push_back({1'b1, 1'b0, b, ~b});
        end
        exp_q.push_back(4'b0100);
    endtask

    // Present a word at a negedge; it is accepted on the following posedge.
    task automatic start_word(input logic [15:0] d, input logic cd);
        @(negedge clk);
        tx_data  = d;
        tx_cd    = cd;
        tx_ready = 1'b1;
        n_cmp++;
        if (tx_busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_before_start: tx_busy=%b want 0", tx_busy);
        end
        @(posedge clk);
    endtask

    // Check the 160 busy cycles and the tx_done cycle after acceptance.
    task automatic check_word(input logic [15:0] d, input logic cd, input int pulse_at,
                              input bit hold, input string name);
        logic [3:0] got;
        logic [3:0] exp;
        build_word(d, cd);
        for (int c = 0; c <= WORD_CYC; c++) begin
            @(negedge clk);
            if (c == 0 && !hold) tx_ready = 1'b0;
            if (pulse_at >= 0 && c == pulse_at) tx_ready = 1'b1;
            if (pulse_at >= 0 && c == pulse_at + 1) tx_ready = 1'b0;
            if (c == 10) begin
                tx_data = 16'($urandom);
                tx_cd   = 1'($urandom);
            end
            got = {tx_busy, tx_done, line_p, line_n};
            exp = exp_q.pop_front();
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s cycle %0d: busy/done/p/n=%b want %b", name, c, got, exp);
            end
        end
    endtask

    task automatic check_idle(input string name);
        logic [3:0] got;
        @(negedge clk);
        got = {tx_busy, tx_done, line_p, line_n};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL %s: busy/done/p/n=%b want 0000", name, got);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic cd, input int pulse_at,
                             input string name);
        start_word(d, cd);
        check_word(d, cd, pulse_at, 1'b0, name);
        check_idle({name, "_after"});
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        tx_ready = 1'b1;
        tx_data  = 16'hABCD;
        tx_cd    = 1'b0;
        repeat (3) @(posedge clk);
        check_idle("reset_state");
        check_idle("reset_no_accept");
        reset    = 1'b0;
        tx_ready = 1'b0;
        check_idle("post_reset_idle");
    endtask

    task automatic test_directed();
        send_word(16'h0860, 1'b0, -1, "cmd_0860");
        send_word(16'hFFFF, 1'b1, -1, "data_ffff");
        send_word(16'h0000, 1'b1, 50, "data_0000_ignore_ready");
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic        cd;
        for (int k = 0; k < 8; k++) begin
            d  = 16'($urandom);
            cd = 1'($urandom);
            send_word(d, cd, (k % 2 == 0) ? int'($urandom_range(5, 150)) : -1, "random_word");
            repeat ($urandom_range(0, 3)) check_idle("random_gap");
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d1;
        logic [15:0] d2;
        logic        cd2;
        d1  = 16'($urandom);
        d2  = 16'($urandom);
        cd2 = 1'($urandom);
        start_word(d1, 1'b0);
        check_word(d1, 1'b0, -1, 1'b1, "b2b_first");
        tx_data = d2;
        tx_cd   = cd2;
        @(posedge clk);
        check_word(d2, cd2, -1, 1'b0, "b2b_second");
        check_idle("b2b_after");
    endtask

    task automatic test_mid_reset();
        logic [3:0]  got;
        logic [15:0] d;
        logic        b;
        d = 16'h5A3C;
        start_word(d, 1'b1);
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (c == 0) tx_ready = 1'b0;
            b   = exp_line(d, 1'b1, c);
            got = {tx_busy, tx_done, line_p, line_n};
            n_cmp++;
            if (got !== {1'b1, 1'b0, b, ~b}) begin
                n_err++;
                $display("FAIL mid_reset_prefix cycle %0d: busy/done/p/n=%b want %b",
                         c, got, {1'b1, 1'b0, b, ~b});
            end
        end
        #2 reset = 1'b1;
        #1;
        got = {tx_busy, tx_done, line_p, line_n};
        n_cmp++;
        if (got !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_reset_async: busy/done/p/n=%b want 0000", got);
        end
        tx_ready = 1'b1;
        check_idle("mid_reset_held");
        check_idle("mid_reset_held2");
        reset   = 1'b0;
        d       = 16'h8001;
        tx_data = d;
        tx_cd   = 1'b0;
        @(posedge clk);
        check_word(d, 1'b0, -1, 1'b0, "after_reset_word");
        check_idle("after_reset_idle");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mkio_transmitter.md
MKIO_TRANSMITTER -- requirements
Module: mkio_transmitter

Interface
REQ-001 SHALL have parameter HALF_BIT, default 8, giving clk cycles per Manchester half-bit (8 → 1 Mbit/s at 16 MHz clk); legal range 2..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tx_ready  input  1  word-transmit request from the terminal controller.
REQ-005 SHALL have port tx_data  input  16  word to send, MSB first.
REQ-006 SHALL have port tx_cd  input  1  sync type: 0 = command/status sync, 1 = data sync.
REQ-007 SHALL have port tx_busy  output  1  high while a word is being serialised.
REQ-008 SHALL have port tx_done  output  1  one-cycle pulse after the final half-bit of a word.
REQ-009 SHALL have port line_p  output  1  positive line drive to the bus transceiver.
REQ-010 SHALL have port line_n  output  1  negative line drive to the bus transceiver.

Function
REQ-011 SHALL accept a word on any clk edge where tx_ready=1 and tx_busy=0, capturing tx_data and tx_cd in that cycle; tx_ready while tx_busy=1 SHALL be ignored.
REQ-012 SHALL assert tx_busy from the cycle after acceptance until the end of the word, and SHALL start line activity in that same cycle.
REQ-013 SHALL emit each word as 40 half-bits of HALF_BIT cycles each, total 40*HALF_BIT cycles: 6 sync, 32 data, 2 parity.
REQ-014 SHALL drive sync for tx_cd=0 as line_p high for 3 half-bits then low for 3; for tx_cd=1 the inverse (low 3, high 3).
REQ-015 SHALL encode each data bit 15 down to 0 as Manchester II: 1 = high then low, 0 = low then high, on line_p.
REQ-016 SHALL append an odd-parity bit (value = XNOR-reduction of the 16 data bits) encoded per REQ-015, making 17 ones-count odd.
REQ-017 SHALL keep line_n = NOT line_p whenever tx_busy=1, and line_p = line_n = 0 whenever tx_busy=0.
REQ-018 SHALL implement states IDLE → SYNC (6 half-bits) → DATA (32 half-bits) → PARITY (2 half-bits) → IDLE, advancing on half-bit timer expiry.
REQ-019 SHALL drop tx_busy and pulse tx_done in the cycle after the last parity half-bit; a tx_ready in that same cycle SHALL be accepted (minimum inter-word gap of 1 clk).
REQ-020 SHALL hold captured data/cd constant through the word regardless of tx_data/tx_cd changes.
REQ-021 SHALL count half-bits with a 6-bit counter and cycles with an 8-bit counter; neither SHALL wrap within a word.

Reset
REQ-022 SHALL, on reset assertion (including mid-word), immediately force state IDLE, tx_busy=0, tx_done=0, line_p=0, line_n=0, counters and shift register to 0.
REQ-023 SHALL accept no word while reset=1; first acceptance possible on the first clk edge after deassertion.

Structure
REQ-024 SHALL take the state encoding, SYNC_HALFBITS=6, DATA_HALFBITS=32, PARITY_HALFBITS=2 and WORD_HALFBITS=40 from shared package mkio_pkg, also used by the receiver.
REQ-025 SHALL place the half-bit cycle timer (load, count, expiry strobe) in one sub-module mkio_bit_timer, parameterised by HALF_BIT.

Verification (HALF_BIT=4, word = 160 clk)
REQ-026 SHALL verify tx_cd=0, tx_data=16'h0860 → line_p = 111000 sync, Manchester of 0000100001100000, parity 0 (lo-hi); tx_busy high 160 cycles, tx_done one pulse.
REQ-027 SHALL verify tx_cd=1, tx_data=16'hFFFF → sync 000111, 16 × hi-lo, parity bit 1 (hi-lo); line_n always complement of line_p while busy.
REQ-028 SHALL verify tx_cd=1, tx_data=16'h0000 → parity bit 1, 16 × lo-hi, and a second tx_ready pulse at cycle 50 is ignored.
REQ-029 SHALL verify back-to-back: tx_ready held high for 2 words → second word starts in the cycle after tx_done, words 161 cycles apart.
REQ-030 SHALL verify reset asserted at cycle 70 of a word → line_p, line_n, tx_busy go 0 without waiting for clk; next tx_ready after release produces a full, correct 160-cycle word.
